// File: rtl/fifo_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_serializer
// Purpose  : Pops wide words from an upstream FIFO dequeue interface and
//            pushes them as p2ratio narrower beats into a downstream FIFO
//            enqueue interface. Sustains one beat per clock with no bubbles
//            between words when the upstream has data and there is no
//            backpressure.
// Options  : FIFO_SER_MSB_FIRST_EN - when defined, the most significant beat
//            of each word is sent first (default: least significant first).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_serializer #(
  parameter int p1width      = 32,
  parameter int p2ratio      = 4,
  parameter int p3cntr_width = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         CLR,
  input  logic [p1width-1:0]           I_D,
  input  logic                         I_EMPTY_N,
  output logic                         I_DEQ,
  output logic [p1width/p2ratio-1:0]   O_D,
  output logic                         O_ENQ,
  input  logic                         O_FULL_N,
  output logic                         BUSY
);

  localparam int                      c_bw        = p1width / p2ratio;
  localparam logic [0:0]              c_st_idle   = 1'b0;
  localparam logic [0:0]              c_st_active = 1'b1;
  localparam logic [p3cntr_width-1:0] c_cnt_last  = p3cntr_width'(p2ratio - 1);

  // Illegal configurations are rejected at elaboration time.
  if (p1width % p2ratio != 0) begin : g_chk_div
    $error("fifo_word_serializer: p1width must be divisible by p2ratio");
  end
  if (p2ratio < 2) begin : g_chk_ratio
    $error("fifo_word_serializer: p2ratio must be at least 2");
  end
  if ($clog2(p2ratio) > p3cntr_width) begin : g_chk_cntr
    $error("fifo_word_serializer: p3cntr_width too small for p2ratio");
  end

  logic [0:0]              r_state;
  logic [p3cntr_width-1:0] r_cnt;
  logic [p1width-1:0]      r_sreg;

  logic                    w_active;
  logic                    w_last;
  logic [p3cntr_width-1:0] w_sel;
  logic [c_bw-1:0]         w_beats [p2ratio];

  assign w_active = (r_state == c_st_active);
  assign w_last   = w_active && (r_cnt == c_cnt_last);

  // Strobes are gated by RST_N so they drop the instant reset asserts,
  // independent of when the clocked state catches up.
  assign O_ENQ = RST_N && w_active && O_FULL_N && !CLR;
  assign I_DEQ = RST_N && I_EMPTY_N && !CLR && (!w_active || (w_last && O_ENQ));
  assign BUSY  = w_active;

  // Split the held word into beat-sized slices; slice k is bits [(k+1)*bw-1 : k*bw].
  for (genvar k = 0; k < p2ratio; k++) begin : g_beat
    assign w_beats[k] = r_sreg[k*c_bw +: c_bw];
  end

`ifdef FIFO_SER_MSB_FIRST_EN
  assign w_sel = c_cnt_last - r_cnt;
`else
  assign w_sel = r_cnt;
`endif

  assign O_D = w_beats[w_sel];

  // Load, advance and retire words; CLR wins over every other event.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else if (CLR) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else if (I_DEQ) begin
      // Covers both the IDLE pop and the back-to-back reload on the last beat.
      r_state <= c_st_active;
      r_cnt   <= '0;
      r_sreg  <= I_D;
    end else if (O_ENQ) begin
      if (w_last) begin
        r_state <= c_st_idle;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Flag handshake violations; by construction these never fire.
  always @(posedge CLK) begin
    if (RST_N) begin
      if (O_ENQ && !O_FULL_N) $warning("fifo_word_serializer: O_ENQ while downstream full");
      if (I_DEQ && !I_EMPTY_N) $warning("fifo_word_serializer: I_DEQ while upstream empty");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_serializer
// Purpose  : Self-checking bench for fifo_word_serializer (32-bit words,
//            4 beats). Per-cycle strobe expectations come from a vector
//            table; beat data is checked against a scoreboard filled when
//            words are popped. Honours FIFO_SER_MSB_FIRST_EN for beat order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_serializer;

  typedef struct {
    bit          add;     // make a new word available upstream this cycle
    logic [31:0] word;
    bit          fn;      // O_FULL_N
    bit          clr;
    bit          e_deq;
    bit          e_enq;
    bit          e_busy;
    logic [31:0] od_word; // when od_k >= 0, O_D must equal beat od_k of od_word
    int          od_k;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] i_d;
  logic        i_empty_n;
  logic        i_deq;
  logic [7:0]  o_d;
  logic        o_enq;
  logic        o_full_n;
  logic        busy;

  int          total;
  int          bad;
  logic [31:0] up_q [$];
  logic [7:0]  sb   [$];
  vec_t        vs   [$];

  fifo_word_serializer #(
    .p1width      (32),
    .p2ratio      (4),
    .p3cntr_width (2)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .CLR       (clr),
    .I_D       (i_d),
    .I_EMPTY_N (i_empty_n),
    .I_DEQ     (i_deq),
    .O_D       (o_d),
    .O_ENQ     (o_enq),
    .O_FULL_N  (o_full_n),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] beat(input logic [31:0] w, input int k);
    logic [31:0] s;
`ifdef FIFO_SER_MSB_FIRST_EN
    s = w >> (8 * (3 - k));
`else
    s = w >> (8 * k);
`endif
    return s[7:0];
  endfunction

  function automatic vec_t mk(input bit add, input logic [31:0] word, input bit fn,
                              input bit c, input bit dq, input bit eq, input bit bz,
                              input logic [31:0] odw, input int odk);
    vec_t v;
    v.add = add; v.word = word; v.fn = fn; v.clr = c;
    v.e_deq = dq; v.e_enq = eq; v.e_busy = bz; v.od_word = odw; v.od_k = odk;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Scoreboard: consume a beat on every enqueue, drop on clear, refill on pop.
  task automatic sample_sb();
    if (o_enq) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL beat_unexpected: got %h want none (t=%0t)", o_d, $time);
      end else begin
        chk("beat_data", {24'h0, o_d}, {24'h0, sb.pop_front()});
      end
    end
    if (clr) sb.delete();
    if (i_deq) for (int k = 0; k < 4; k++) sb.push_back(beat(i_d, k));
  endtask

  task automatic drive_up();
    i_empty_n = (up_q.size() != 0);
    i_d       = (up_q.size() != 0) ? up_q[0] : 32'h0;
  endtask

  // One clock: drive just after posedge, sample at negedge, act on the pop.
  task automatic step(input vec_t v);
    logic deq_s;
    if (v.add) up_q.push_back(v.word);
    drive_up();
    o_full_n = v.fn;
    clr      = v.clr;
    @(negedge clk);
    chk("i_deq", {31'h0, i_deq}, {31'h0, v.e_deq});
    chk("o_enq", {31'h0, o_enq}, {31'h0, v.e_enq});
    chk("busy",  {31'h0, busy},  {31'h0, v.e_busy});
    if (v.od_k >= 0) chk("od_hold", {24'h0, o_d}, {24'h0, beat(v.od_word, v.od_k)});
    sample_sb();
    deq_s = i_deq;
    @(posedge clk);
    #1;
    if (deq_s && up_q.size() != 0) void'(up_q.pop_front());
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; clr = 1'b0; o_full_n = 1'b1;
    i_empty_n = 1'b1; i_d = 32'hFFFF_FFFF;

    // Reset state with upstream claiming data: strobes must stay low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_deq",  {31'h0, i_deq}, 32'h0);
    chk("rst_enq",  {31'h0, o_enq}, 32'h0);
    chk("rst_busy", {31'h0, busy},  32'h0);
    chk("rst_od",   {24'h0, o_d},   32'h0);
    @(posedge clk); #1;
    i_empty_n = 1'b0;
    rst_n     = 1'b1;

    // Single word
    vs.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 1, 0, 0, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, -1));
    // Back-to-back words, pop on the last beat
    vs.push_back(mk(1, 32'h11223344, 1, 0, 1, 0, 0, 0, -1));
    vs.push_back(mk(1, 32'h55667788, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, -1));
    // Three-cycle stall on the third beat
    vs.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 1, 0, 0, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA1B2C3D4, 2));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA1B2C3D4, 2));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hA1B2C3D4, 2));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, -1));
    // Stall on the last beat blocks the next pop
    vs.push_back(mk(1, 32'h01020304, 1, 0, 1, 0, 0, 0, -1));
    vs.push_back(mk(1, 32'h0A0B0C0D, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h01020304, 3));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h01020304, 3));
    vs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, -1));
    // CLR after the second beat, next word starts fresh
    vs.push_back(mk(1, 32'hA1B2C3D4, 1, 0, 1, 0, 0, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(1, 32'hDEADBEEF, 1, 1, 0, 0, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    vs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, -1));

    for (int i = 0; i < vs.size(); i++) step(vs[i]);

    // Asynchronous reset in the middle of a word
    step(mk(1, 32'h12345678, 1, 0, 1, 0, 0, 0, -1));
    step(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    up_q.push_back(32'hCAFEF00D);
    drive_up();
    o_full_n = 1'b1;
    clr      = 1'b0;
    #2;
    chk("pre_rst_enq", {31'h0, o_enq}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_enq",  {31'h0, o_enq}, 32'h0);
    chk("arst_deq",  {31'h0, i_deq}, 32'h0);
    chk("arst_busy", {31'h0, busy},  32'h0);
    sb.delete();
    @(posedge clk); #1;
    chk("arst_hold_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    step(mk(0, 0, 1, 0, 1, 0, 0, 0, -1));
    step(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    step(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    step(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    step(mk(0, 0, 1, 0, 0, 1, 1, 0, -1));
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, -1));

    chk("sb_drained", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
